// File: rtl/mem_responder_if.sv
// mem_responder_if: strobe/address/data request and ready/busy/error response bundle between control unit and memory responder
interface mem_responder_if;
  logic        MEMRead;
  logic        MEMWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [1:0]  Size;
  logic [31:0] MemData;
  logic        MemReady;
  logic        MemBusy;
  logic        MemErr;
  modport master (
    output MEMRead, MEMWrite, Address, WriteData, Size,
    input  MemData, MemReady, MemBusy, MemErr
  );
  modport slave (
    input  MEMRead, MEMWrite, Address, WriteData, Size,
    output MemData, MemReady, MemBusy, MemErr
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM serving word/half/byte accesses after a fixed latency, signalling completion with MemReady
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        ready_q, ready_d, busy_q, busy_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] ram [DEPTH];
  logic        accept, commit, c_rd, c_wr, c_fault, we;
  logic [31:0] c_addr, c_wdata, c_word, rdata, wlane;
  logic [1:0]  c_size;
  logic [3:0]  be;
  assign accept = state_q != WAIT && (bus.MEMRead || bus.MEMWrite);
  // With single-cycle latency the access completes on the accepting edge, so it works from the live request
  assign commit  = LATENCY == 1 ? accept : state_q == WAIT && cnt_q == 3'(LATENCY - 1);
  assign c_rd    = LATENCY == 1 ? bus.MEMRead   : rd_q;
  assign c_wr    = LATENCY == 1 ? bus.MEMWrite  : wr_q;
  assign c_addr  = LATENCY == 1 ? bus.Address   : addr_q;
  assign c_wdata = LATENCY == 1 ? bus.WriteData : wdata_q;
  assign c_size  = LATENCY == 1 ? bus.Size      : size_q;
  assign c_fault = (c_rd && c_wr) || c_size == 2'b11 || (c_size == 2'b01 && c_addr[0]) ||
                   (c_size == 2'b00 && c_addr[1:0] != 2'b00) || c_addr >= 32'(DEPTH * 4);
  assign c_word  = ram[c_addr[AW+1:2]];
  assign rdata   = c_size == 2'b00 ? c_word :
                   c_size == 2'b01 ? {16'b0, c_word[{c_addr[1], 4'b0} +: 16]} :
                                     {24'b0, c_word[{c_addr[1:0], 3'b0} +: 8]};
  assign wlane   = c_size == 2'b00 ? c_wdata :
                   c_size == 2'b01 ? {2{c_wdata[15:0]}} : {4{c_wdata[7:0]}};
  assign be      = c_size == 2'b00 ? 4'hf :
                   c_size == 2'b01 ? (c_addr[1] ? 4'hc : 4'h3) : 4'b0001 << c_addr[1:0];
  assign we      = reset && commit && c_wr && !c_fault;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    ready_d = commit;
    err_d   = commit && c_fault;
    data_d  = commit && c_rd && !c_fault ? rdata : data_q;
    busy_d  = accept || (busy_q && state_q != RESP);
    if (accept) begin
      state_d = LATENCY == 1 ? RESP : WAIT;
      cnt_d   = LATENCY == 1 ? 3'd0 : 3'd1;
      rd_d    = bus.MEMRead;
      wr_d    = bus.MEMWrite;
      addr_d  = bus.Address;
      wdata_d = bus.WriteData;
      size_d  = bus.Size;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (state_q == WAIT) begin
      state_d = commit ? RESP : WAIT;
      cnt_d   = commit ? 3'd0 : cnt_q + 3'd1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we)
      for (int l = 0; l < 4; l++)
        if (be[l]) ram[c_addr[AW+1:2]][8*l +: 8] <= wlane[8*l +: 8];
  end
  assign bus.MemData  = data_q;
  assign bus.MemReady = ready_q;
  assign bus.MemBusy  = busy_q;
  assign bus.MemErr   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench with a byte-array reference model, directed scenarios and randomized accesses
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [7:0]  mm [DEPTH*4];
  logic [31:0] last_rd = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_responder_if bus();
  mem_responder_if bus1();
  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_responder #(.DEPTH(DEPTH), .LATENCY(1))   dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 4 : s == 2'd1 ? 2 : 1;
  endfunction

  function automatic logic is_fault(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] s);
    return (rd && wr) || s == 2'd3 || (a % nbytes(s)) != 0 || a >= 32'(DEPTH * 4);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.MemErr && !bus.MemReady) check("err_without_ready", {31'b0, bus.MemErr}, 32'd0);
    if (bus.MemReady) begin
      if (sb.size() == 0) check("unexpected_ready", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        check("resp_err", {31'b0, bus.MemErr}, {31'b0, e.err});
        check("resp_data", bus.MemData, e.data);
        check("resp_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, output int acc);
    bus.MEMRead = rd; bus.MEMWrite = wr; bus.Address = a; bus.WriteData = d; bus.Size = s;
    @(posedge clk); #1;
    acc = cyc;
    bus.MEMRead = 1'b0; bus.MEMWrite = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    int acc;
    exp_t e;
    drive(rd, wr, a, d, s, acc);
    e.err = is_fault(rd, wr, a, s);
    e.due = acc + LAT - 1;
    if (!e.err && wr) for (int i = 0; i < nbytes(s); i++) mm[a + i] = d[8*i +: 8];
    if (!e.err && rd) begin
      last_rd = '0;
      for (int i = 0; i < nbytes(s); i++) last_rd[8*i +: 8] = mm[a + i];
    end
    e.data = last_rd;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!bus.MemBusy) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", {31'b0, bus.MemBusy}, 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (bus.MemReady) return;
      @(posedge clk); #1;
    end
    check("ready_timeout", {31'b0, bus.MemReady}, 32'd1);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [1:0] s, input logic [31:0] exp, input string name);
    issue(1'b1, 1'b0, a, 32'd0, s);
    wait_idle();
    check(name, bus.MemData, exp);
  endtask

  task automatic lat1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s);
    bus1.MEMRead = rd; bus1.MEMWrite = wr; bus1.Address = a; bus1.WriteData = d; bus1.Size = s;
    @(posedge clk); #1;
    bus1.MEMRead = 1'b0; bus1.MEMWrite = 1'b0;
    check("lat1_ready_hi", {31'b0, bus1.MemReady}, 32'd1);
    check("lat1_busy_hi", {31'b0, bus1.MemBusy}, 32'd1);
    @(posedge clk); #1;
    check("lat1_ready_lo", {31'b0, bus1.MemReady}, 32'd0);
    check("lat1_busy_lo", {31'b0, bus1.MemBusy}, 32'd0);
  endtask

  initial begin
    logic [31:0] old30;
    bus.MEMRead = 0; bus.MEMWrite = 0; bus.Address = 0; bus.WriteData = 0; bus.Size = 0;
    bus1.MEMRead = 0; bus1.MEMWrite = 0; bus1.Address = 0; bus1.WriteData = 0; bus1.Size = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", bus.MemData, 32'd0);
    check("rst_ready", {31'b0, bus.MemReady}, 32'd0);
    check("rst_busy", {31'b0, bus.MemBusy}, 32'd0);
    check("rst_err", {31'b0, bus.MemErr}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < DEPTH; w++) begin
      issue(1'b0, 1'b1, 32'(w * 4), $urandom, 2'd0);
      wait_idle();
    end
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd0);
    wait_idle();
    rd_chk(32'h10, 2'd0, 32'hDEADBEEF, "t1_word");
    issue(1'b0, 1'b1, 32'h11, 32'h0000005A, 2'd2);
    wait_idle();
    rd_chk(32'h10, 2'd0, 32'hDEAD5AEF, "t2_word");
    rd_chk(32'h12, 2'd1, 32'h0000DEAD, "t2_half");
    rd_chk(32'h13, 2'd2, 32'h000000DE, "t2_byte");
    issue(1'b1, 1'b0, 32'h02, 32'd0, 2'd0);            wait_idle();
    issue(1'b0, 1'b1, 32'h01, 32'hFFFF, 2'd1);         wait_idle();
    issue(1'b1, 1'b0, 32'(DEPTH * 4), 32'd0, 2'd0);    wait_idle();
    issue(1'b1, 1'b1, 32'h10, 32'h0, 2'd0);            wait_idle();
    issue(1'b1, 1'b0, 32'h10, 32'd0, 2'd3);            wait_idle();
    check("t3_data_held", bus.MemData, 32'h000000DE);
    rd_chk(32'h10, 2'd0, 32'hDEAD5AEF, "t3_ram_kept");
    issue(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 2'd0);
    bus.MEMWrite = 1'b1; bus.Address = 32'h20; bus.WriteData = 32'h11112222; bus.Size = 2'd0;
    @(posedge clk); #1;
    bus.MEMWrite = 1'b0;
    wait_idle();
    rd_chk(32'h20, 2'd0, 32'hAAAA5555, "t4_single_write");
    issue(1'b1, 1'b0, 32'h10, 32'd0, 2'd0);
    wait_ready();
    issue(1'b1, 1'b0, 32'h20, 32'd0, 2'd0);
    check("t4_b2b_busy", {31'b0, bus.MemBusy}, 32'd1);
    wait_idle();
    check("t4_b2b_data", bus.MemData, 32'hAAAA5555);
    old30 = {mm[32'h33], mm[32'h32], mm[32'h31], mm[32'h30]};
    begin
      int acc;
      drive(1'b0, 1'b1, 32'h30, 32'h12345678, 2'd0, acc);
    end
    reset = 1'b0;
    #1;
    check("t5_data", bus.MemData, 32'd0);
    check("t5_ready", {31'b0, bus.MemReady}, 32'd0);
    check("t5_busy", {31'b0, bus.MemBusy}, 32'd0);
    check("t5_err", {31'b0, bus.MemErr}, 32'd0);
    last_rd = '0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    rd_chk(32'h30, 2'd0, old30, "t5_old_value");
    for (int n = 0; n < 250; n++) begin
      int k;
      logic rd, wr;
      logic [1:0] s;
      logic [31:0] a;
      k  = $urandom_range(0, 15);
      rd = k == 0 || k[0];
      wr = k == 0 || !k[0];
      s  = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, DEPTH * 4 + 8));
      else a = 32'($urandom_range(0, DEPTH - 1) * 4) +
               (s == 2'd1 ? 32'($urandom_range(0, 1) * 2) : s == 2'd2 ? 32'($urandom_range(0, 3)) : 32'd0);
      issue(rd, wr, a, $urandom, s);
      if ($urandom_range(0, 2) == 0) wait_ready();
      else wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    lat1(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'd0);
    lat1(1'b1, 1'b0, 32'h41, 32'd0, 2'd2);
    check("lat1_byte", bus1.MemData, 32'h000000F0);
    lat1(1'b1, 1'b0, 32'h40, 32'd0, 2'd0);
    check("lat1_word", bus1.MemData, 32'hCAFEF00D);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
